// File: rtl/gate_check_seq.sv
// gate_check_seq: steps a 2-input gate through all four input vectors,
// samples O after a settle delay and compares against a truth table.
module gate_check_seq #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       truth,
  input  logic             O,
  output logic             I1,
  output logic             I2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_mask,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] fail_cnt
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [3:0] SC_LAST  = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] S_FIRST  = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

  logic [1:0]       state_q, state_d, vec_q, vec_d, io_q, io_d;
  logic [3:0]       cnt_q, cnt_d, truth_q, truth_d, mask_q, mask_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CNT_W-1:0] run_q, run_d, fail_q, fail_d;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    truth_d = truth_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    run_d   = run_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: if (start && !abort) begin
        truth_d = truth;
        vec_d   = 2'd0;
        cnt_d   = 4'd0;
        mask_d  = 4'd0;
        pass_d  = 1'b0;
        state_d = S_FIRST;
      end
      S_SETTLE: if (abort) begin
        state_d = S_IDLE;
        vec_d   = 2'd0;
        mask_d  = 4'd0;
        pass_d  = 1'b0;
      end else if (cnt_q == SC_LAST) state_d = S_SAMPLE;
      else cnt_d = cnt_q + 4'd1;
      S_SAMPLE: if (abort) begin
        state_d = S_IDLE;
        vec_d   = 2'd0;
        mask_d  = 4'd0;
        pass_d  = 1'b0;
      end else begin
        mask_d = mask_q | ((O != truth_q[vec_q]) ? (4'b0001 << vec_q) : 4'd0);
        if (vec_q == 2'd3) begin
          // Results and counters become visible together with the done pulse.
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (mask_d == 4'd0);
          run_d   = &run_q ? run_q : run_q + 1'b1;
          fail_d  = (mask_d == 4'd0 || &fail_q) ? fail_q : fail_q + 1'b1;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = S_FIRST;
        end
      end
      default: begin
        state_d = S_IDLE;
        vec_d   = 2'd0;
      end
    endcase
  end

  assign io_d   = (state_d == S_SETTLE || state_d == S_SAMPLE) ? vec_d : 2'd0;
  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      truth_q <= 4'd0;
      mask_q  <= 4'd0;
      io_q    <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      run_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      truth_q <= truth_d;
      mask_q  <= mask_d;
      io_q    <= io_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      run_q   <= run_d;
      fail_q  <= fail_d;
    end
  end

  assign I1        = io_q[1];
  assign I2        = io_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = mask_q;
  assign run_cnt   = run_q;
  assign fail_cnt  = fail_q;
endmodule

// File: tb/tb_gate_check_seq.sv
// tb_gate_check_seq: two checkers (settle 2 / 8-bit counters and settle 0 / 2-bit
// counters) driving a modelled gate; run results go through a scoreboard queue.
module tb_gate_check_seq;
  typedef struct {
    logic [3:0] mask;
    logic       pass;
    int         run;
    int         fail;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v [2];
  logic       abort_v [2];
  logic [3:0] truth_v [2];
  int         gsel [2];
  int         erun [2];
  int         efail [2];
  exp_t       sb [$];
  int         checks = 0;
  int         errors = 0;
  logic       cur = 1'b0;

  logic       O0, I1_0, I2_0, busy0, done0, pass0;
  logic [3:0] fm0;
  logic [7:0] run0, fail0;
  logic       O1, I1_1, I2_1, busy1, done1, pass1;
  logic [3:0] fm1;
  logic [1:0] run1, fail1;

  always #5 clk = ~clk;

  function automatic logic gate(input int s, input logic a, input logic b);
    return (s == 0) ? (a | b) : (s == 1) ? (a & b) : 1'b1;
  endfunction

  assign O0 = gate(gsel[0], I1_0, I2_0);
  assign O1 = gate(gsel[1], I1_1, I2_1);

  gate_check_seq #(.SETTLE_CYCLES(2), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .truth(truth_v[0]),
    .O(O0), .I1(I1_0), .I2(I2_0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_mask(fm0), .run_cnt(run0), .fail_cnt(fail0)
  );

  gate_check_seq #(.SETTLE_CYCLES(0), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .truth(truth_v[1]),
    .O(O1), .I1(I1_1), .I2(I2_1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(fm1), .run_cnt(run1), .fail_cnt(fail1)
  );

  logic [1:0] v_io;
  logic       v_busy, v_done, v_pass;
  logic [3:0] v_fm;
  logic [7:0] v_run, v_fail;
  assign v_io   = cur ? {I1_1, I2_1} : {I1_0, I2_0};
  assign v_busy = cur ? busy1 : busy0;
  assign v_done = cur ? done1 : done0;
  assign v_pass = cur ? pass1 : pass0;
  assign v_fm   = cur ? fm1 : fm0;
  assign v_run  = cur ? {6'd0, run1} : run0;
  assign v_fail = cur ? {6'd0, fail1} : fail0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int d, input int sel, input logic [3:0] tt, input bit hold);
    exp_t e, g;
    int lat, mx;
    bit got;
    cur = d[0];
    lat = (d == 1) ? 4 : 12;
    mx = (d == 1) ? 3 : 255;
    e.mask = 4'd0;
    for (int v = 0; v < 4; v++) e.mask[v] = (gate(sel, v[1], v[0]) != tt[v]);
    e.pass = (e.mask == 4'd0);
    if (erun[d] < mx) erun[d]++;
    if (!e.pass && efail[d] < mx) efail[d]++;
    e.run = erun[d];
    e.fail = efail[d];
    sb.push_back(e);
    gsel[d] = sel;
    truth_v[d] = tt;
    start_v[d] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < lat + 8 && !got; k++) begin
      @(negedge clk);
      if (!hold) start_v[d] = 1'b0;
      truth_v[d] = ~tt;
      if (k < lat) chk("ivec", v_io, k / (lat / 4));
      if (v_done) begin
        got = 1'b1;
        g = sb.pop_front();
        chk("latency", k, lat);
        chk("mask", v_fm, g.mask);
        chk("pass", v_pass, g.pass);
        chk("run_cnt", v_run, g.run);
        chk("fail_cnt", v_fail, g.fail);
      end
    end
    chk("done_seen", got, 1);
    if (!got) sb.delete();
    @(negedge clk);
    chk("done_pulse", {v_done, v_busy}, 0);
    start_v[d] = 1'b0;
    @(negedge clk);
    chk("idle_after", v_busy, 0);
  endtask

  initial begin
    int dn;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      truth_v[i] = 4'd0;
      gsel[i] = 0;
      erun[i] = 0;
      efail[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst0_flags", {busy0, done0, pass0, fm0, I1_0, I2_0}, 0);
    chk("rst0_cnt", {run0, fail0}, 0);
    chk("rst1_flags", {busy1, done1, pass1, fm1, I1_1, I2_1}, 0);
    chk("rst1_cnt", {run1, fail1}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 0, 4'b1110, 0);
    run(0, 0, 4'b1000, 0);

    // abort during the second settle cycle of vector 2
    cur = 1'b0;
    gsel[0] = 0;
    truth_v[0] = 4'b1000;
    start_v[0] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    chk("pre_abort_i", {I1_0, I2_0}, 2'b10);
    chk("pre_abort_mask", fm0, 4'b0010);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort_i", {I1_0, I2_0}, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_clear", {done0, pass0, fm0}, 0);
    chk("abort_run", run0, erun[0]);
    chk("abort_fail", fail0, efail[0]);
    dn = 0;
    repeat (14) begin
      @(negedge clk);
      dn += int'(done0);
    end
    chk("abort_nodone", dn, 0);

    run(0, 0, 4'b1110, 0);
    run(0, 0, 4'b1110, 1);

    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    chk("start_abort_idle", busy0, 0);
    chk("start_abort_pass", pass0, 1);

    run(1, 2, 4'b1111, 0);
    repeat (5) run(1, 2, 4'b0000, 0);
    chk("sat_run", run1, 2'd3);
    chk("sat_fail", fail1, 2'd3);

    // asynchronous reset in the middle of a run on both checkers
    start_v[0] = 1'b1;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", {busy0, busy1}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("arst0_flags", {busy0, done0, pass0, fm0, I1_0, I2_0}, 0);
    chk("arst0_cnt", {run0, fail0}, 0);
    chk("arst1_flags", {busy1, done1, pass1, fm1, I1_1, I2_1}, 0);
    chk("arst1_cnt", {run1, fail1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (16) begin
      @(negedge clk);
      dn += int'(done0) + int'(done1) + int'(busy0) + int'(busy1);
    end
    chk("post_rst_quiet", dn, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
